// File: rtl/frac_search_pkg.sv
// Shared definitions for the fractional motion-search sequencer.
//   state_t     : sequencer states
//   DEF_*       : default geometry of the search
//   LINES       : padded-block lines streamed per candidate (HEIGHT+TAPS-1)
//   PRIME       : lines that only prime the filter taps (TAPS-1)
package frac_search_pkg;

    localparam int DEF_HEIGHT   = 8;
    localparam int DEF_TAPS     = 8;
    localparam int DEF_NUM_CAND = 8;
    localparam int DEF_COST_W   = 16;

    localparam int LINES = DEF_HEIGHT + DEF_TAPS - 1;
    localparam int PRIME = DEF_TAPS - 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        STREAM    = 3'd2,
        WAIT_COST = 3'd3,
        DONE      = 3'd4
    } state_t;

endpackage

// File: rtl/frac_min_tracker.sv
// Running minimum over the per-candidate costs of one search.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   clear        : start of a new search; best_cand <- 0, best_cost <- all-ones
//   load_first   : the offered cost belongs to candidate 0 and always loads
//   cost_valid   : cost/cand are an accepted candidate result this cycle
//   cost, cand   : candidate result
//   best_cand    : index of the lowest cost seen (ties keep the lower index)
//   best_cost    : lowest cost seen
module frac_min_tracker #(
    parameter int COST_W = 16,
    parameter int CAND_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load_first,
    input  logic              cost_valid,
    input  logic [COST_W-1:0] cost,
    input  logic [CAND_W-1:0] cand,
    output logic [CAND_W-1:0] best_cand,
    output logic [COST_W-1:0] best_cost
);

    logic take;

    // Strict less-than: an equal cost from a later candidate never displaces
    // the earlier one.
    assign take = cost_valid && (load_first || (cost < best_cost));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            best_cand <= '0;
            best_cost <= '1;
        end else if (take) begin
            best_cand <= cand;
            best_cost <= cost;
        end
    end

endmodule

// File: rtl/frac_search_seq.sv
// Fractional motion-search sequencer. For each candidate it streams the
// lines of the padded block into the interpolation filter (first TAPS-1
// lines only prime the taps, then filter and reference lines go together),
// waits for the candidate cost and keeps the lowest-cost candidate.
//
// Build option: FRAC_SEARCH_EARLY_TERM_EN -- when defined, an accepted cost
// of 0 finishes the search immediately after recording that candidate.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : begin a search (only sampled in IDLE)
//   busy        : high whenever not IDLE
//   src_ready   : line buffers can deliver the addressed lines this cycle
//   filt_addr   : padded-block line index (the line counter itself)
//   ref_addr    : reference line index during STREAM
//   cand        : current candidate / filter phase
//   filt_valid  : filter line accepted this cycle (combinational)
//   ref_valid   : reference line accepted this cycle (combinational)
//   acc_clr     : first FILL cycle of each candidate
//   cost        : candidate cost, qualified by cost_valid
//   done        : one-cycle completion pulse
//   best_cand   : lowest-cost candidate
//   best_cost   : lowest cost
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start
// FILL      | priming lines 0..TAPS-2, filter only
// STREAM    | lines TAPS-1..HEIGHT+TAPS-2, filter and reference together
// WAIT_COST | waiting for the datapath cost of the current candidate
// DONE      | completion pulse, then back to IDLE
module frac_search_seq
    import frac_search_pkg::*;
#(
    parameter int HEIGHT   = DEF_HEIGHT,
    parameter int TAPS     = DEF_TAPS,
    parameter int NUM_CAND = DEF_NUM_CAND,
    parameter int COST_W   = DEF_COST_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    output logic                                busy,
    input  logic                                src_ready,
    output logic [$clog2(HEIGHT+TAPS-1)-1:0]    filt_addr,
    output logic [$clog2(HEIGHT)-1:0]           ref_addr,
    output logic [$clog2(NUM_CAND)-1:0]         cand,
    output logic                                filt_valid,
    output logic                                ref_valid,
    output logic                                acc_clr,
    input  logic [COST_W-1:0]                   cost,
    input  logic                                cost_valid,
    output logic                                done,
    output logic [$clog2(NUM_CAND)-1:0]         best_cand,
    output logic [COST_W-1:0]                   best_cost
);

    localparam int FW = $clog2(HEIGHT + TAPS - 1);
    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(NUM_CAND);

    localparam logic [FW-1:0] LAST_PRIME_LINE = FW'(TAPS - 2);
    localparam logic [FW-1:0] LAST_LINE       = FW'(HEIGHT + TAPS - 2);
    localparam logic [CW-1:0] LAST_CAND       = CW'(NUM_CAND - 1);

    state_t          state, state_nxt;
    logic [FW-1:0]   lidx, lidx_nxt;
    logic [RW-1:0]   ref_addr_nxt;
    logic [CW-1:0]   cand_nxt;
    logic            acc_clr_nxt;
    logic            done_nxt;
    logic            busy_nxt;

    logic            search_start;
    logic            cost_take;
    logic            early_stop;

    assign filt_addr    = lidx;
    assign search_start = (state == IDLE) && start;
    // Costs are only meaningful while the datapath is expected to deliver one.
    assign cost_take    = (state == WAIT_COST) && cost_valid;

`ifdef FRAC_SEARCH_EARLY_TERM_EN
    assign early_stop = (cost == '0);
`else
    assign early_stop = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        lidx_nxt     = lidx;
        ref_addr_nxt = ref_addr;
        cand_nxt     = cand;
        acc_clr_nxt  = 1'b0;
        done_nxt     = 1'b0;
        filt_valid   = 1'b0;
        ref_valid    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = FILL;
                    lidx_nxt     = '0;
                    ref_addr_nxt = '0;
                    cand_nxt     = '0;
                    acc_clr_nxt  = 1'b1;
                end
            end

            FILL: begin
                filt_valid = src_ready;
                if (src_ready) begin
                    lidx_nxt = lidx + 1'b1;
                    if (lidx == LAST_PRIME_LINE) begin
                        state_nxt    = STREAM;
                        ref_addr_nxt = '0;
                    end
                end
            end

            STREAM: begin
                filt_valid = src_ready;
                ref_valid  = src_ready;
                if (src_ready) begin
                    // The counter parks on the last line while the cost is
                    // outstanding so filt_addr never leaves its legal range.
                    if (lidx == LAST_LINE) begin
                        state_nxt = WAIT_COST;
                    end else begin
                        lidx_nxt     = lidx + 1'b1;
                        ref_addr_nxt = ref_addr + 1'b1;
                    end
                end
            end

            WAIT_COST: begin
                if (cost_valid) begin
                    if ((cand == LAST_CAND) || early_stop) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt    = FILL;
                        cand_nxt     = cand + 1'b1;
                        lidx_nxt     = '0;
                        ref_addr_nxt = '0;
                        acc_clr_nxt  = 1'b1;
                    end
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            lidx     <= '0;
            ref_addr <= '0;
            cand     <= '0;
            acc_clr  <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            lidx     <= lidx_nxt;
            ref_addr <= ref_addr_nxt;
            cand     <= cand_nxt;
            acc_clr  <= acc_clr_nxt;
            done     <= done_nxt;
            busy     <= busy_nxt;
        end
    end

    frac_min_tracker #(
        .COST_W (COST_W),
        .CAND_W (CW)
    ) u_min_tracker (
        .clk        (clk),
        .reset      (reset),
        .clear      (search_start),
        .load_first (cand == '0),
        .cost_valid (cost_take),
        .cost       (cost),
        .cand       (cand),
        .best_cand  (best_cand),
        .best_cost  (best_cost)
    );

endmodule
